// File: rtl/l2_mem_arbiter_pkg.sv
// Shared widths, FSM encoding and requester identifiers for the L2 memory arbiter.
package l2_mem_arbiter_pkg;

  localparam int ADDR_W_DEF = 28;
  localparam int DATA_W_DEF = 128;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Value held in last_grant; grant vectors use bit 0 = I-side, bit 1 = D-side.
  localparam logic SIDE_I = 1'b0;
  localparam logic SIDE_D = 1'b1;

endpackage

// File: rtl/l2_mem_arbiter_rr_pick2.sv
// Two-way round-robin picker: one-hot grant, contention goes to the side not granted last.
module rr_pick2
  import l2_mem_arbiter_pkg::*;
(
  input  logic       req_i,
  input  logic       req_d,
  input  logic       last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    if (req_i && req_d) begin
      grant = (last_grant == SIDE_I) ? 2'b10 : 2'b01;
    end else if (req_i) begin
      grant = 2'b01;
    end else if (req_d) begin
      grant = 2'b10;
    end
  end

endmodule

// File: rtl/l2_mem_arbiter.sv
// Arbitrates I-side and D-side L2 miss traffic onto one memory port, one transaction at a time.
module l2_mem_arbiter
  import l2_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              proc_reset,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ready,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  state_t     state;
  state_t     state_nxt;
  logic       last_grant;
  logic       d_req;
  logic [1:0] grant;

  // A D-side request with both read and write raised is malformed and not arbitrated.
  assign d_req = d_read ^ d_write;

  rr_pick2 u_pick (
    .req_i      (i_read),
    .req_d      (d_req),
    .last_grant (last_grant),
    .grant      (grant)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (grant[0]) begin
          state_nxt = BUSY_I;
        end else if (grant[1]) begin
          state_nxt = BUSY_D;
        end
      end
      BUSY_I, BUSY_D: begin
        if (mem_ready) begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The mem_* registers double as the transaction latches: loaded once on grant, then held.
  always_ff @(posedge clk) begin
    if (proc_reset) begin
      state      <= IDLE;
      last_grant <= SIDE_I;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      i_ready    <= 1'b0;
      d_ready    <= 1'b0;
      i_rdata    <= '0;
      d_rdata    <= '0;
    end else begin
      state   <= state_nxt;
      i_ready <= 1'b0;
      d_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (grant[0]) begin
            mem_read   <= 1'b1;
            mem_write  <= 1'b0;
            mem_addr   <= i_addr;
            last_grant <= SIDE_I;
          end else if (grant[1]) begin
            mem_read   <= d_read;
            mem_write  <= d_write;
            mem_addr   <= d_addr;
            mem_wdata  <= d_wdata;
            last_grant <= SIDE_D;
          end
        end
        BUSY_I, BUSY_D: begin
          if (mem_ready) begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            if (state == BUSY_I) begin
              i_ready <= 1'b1;
              if (mem_read) begin
                i_rdata <= mem_rdata;
              end
            end else begin
              d_ready <= 1'b1;
              if (mem_read) begin
                d_rdata <= mem_rdata;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_l2_mem_arbiter.sv
// Self-checking bench for l2_mem_arbiter: vector table, corner sequences, randomized run.
module tb_l2_mem_arbiter;

  localparam int AW = 28;
  localparam int DW = 128;

  logic          clk = 1'b0;
  logic          proc_reset = 1'b1;
  logic          i_read = 1'b0;
  logic [AW-1:0] i_addr = '0;
  logic [DW-1:0] i_rdata;
  logic          i_ready;
  logic          d_read = 1'b0;
  logic          d_write = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic [DW-1:0] d_rdata;
  logic          d_ready;
  logic          mem_read;
  logic          mem_write;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_ready = 1'b0;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  l2_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk        (clk),
    .proc_reset (proc_reset),
    .i_read     (i_read),
    .i_addr     (i_addr),
    .i_rdata    (i_rdata),
    .i_ready    (i_ready),
    .d_read     (d_read),
    .d_write    (d_write),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .d_rdata    (d_rdata),
    .d_ready    (d_ready),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready)
  );

  typedef struct {
    bit            sd;
    bit            wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd;
    int            lat;
    logic [DW-1:0] rd;
    logic [DW-1:0] exp_rdata;
  } vec_t;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic clear_inputs();
    i_read = 1'b0;
    d_read = 1'b0;
    d_write = 1'b0;
    mem_ready = 1'b0;
    mem_rdata = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    proc_reset = 1'b1;
    clear_inputs();
    @(negedge clk);
    @(negedge clk);
    proc_reset = 1'b0;
  endtask

  // Single requester transaction; memory answers in the lat-th strobe cycle.
  task automatic do_txn(input vec_t v, output int first_s, output int scyc, output int own_rdy,
                        output int oth_rdy, output logic [AW-1:0] s_addr,
                        output logic [DW-1:0] s_wd, output logic [1:0] s_op);
    bit drop_now;
    first_s = -1; scyc = 0; own_rdy = 0; oth_rdy = 0;
    s_addr = '0; s_wd = '0; s_op = '0;
    @(negedge clk);
    if (v.sd) begin
      d_read = !v.wr; d_write = v.wr; d_addr = v.addr; d_wdata = v.wd;
    end else begin
      i_read = 1'b1; i_addr = v.addr;
    end
    for (int k = 1; k <= v.lat + 4; k++) begin
      @(posedge clk); #1;
      if (mem_read || mem_write) begin
        if (first_s < 0) first_s = k;
        scyc++;
        s_addr = mem_addr; s_wd = mem_wdata; s_op = {mem_write, mem_read};
      end
      own_rdy += v.sd ? int'(d_ready) : int'(i_ready);
      oth_rdy += v.sd ? int'(i_ready) : int'(d_ready);
      drop_now = v.sd ? d_ready : i_ready;
      @(negedge clk);
      mem_ready = (mem_read || mem_write) && (scyc == v.lat);
      mem_rdata = v.rd;
      if (drop_now) begin
        i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
      end
    end
    mem_ready = 1'b0;
  endtask

  // Both sides request repeatedly; grant order recorded as bits (1 = D), newest in bit 0.
  task automatic contend(input int ni, input int nd, input logic [AW-1:0] ia,
                         input logic [AW-1:0] da, input bit dwr, input logic [DW-1:0] dwd,
                         output logic [15:0] ord, output int n, output int coincide,
                         output int bad_op, output int left);
    int ip, dp, scnt;
    bit idrop, ddrop, strobe_s, st, side, dv;
    ip = ni; dp = nd; idrop = 0; ddrop = 0; scnt = 0; strobe_s = 0;
    ord = '0; n = 0; coincide = 0; bad_op = 0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      @(negedge clk);
      mem_ready = strobe_s && (scnt == 2);
      i_addr = ia; d_addr = da; d_wdata = dwd;
      i_read = (ip > 0) && !idrop;
      idrop = 0;
      dv = (dp > 0) && !ddrop;
      ddrop = 0;
      d_read = dv && !dwr;
      d_write = dv && dwr;
      if (ip == 0 && dp == 0) break;
      @(posedge clk); #1;
      st = mem_read || mem_write;
      if (st && !strobe_s) begin
        side = (mem_addr == da);
        ord = {ord[14:0], side};
        n++;
        scnt = 0;
        if (side && ((mem_write != dwr) || (mem_read == dwr) || (dwr && mem_wdata !== dwd))) bad_op++;
        if (!side && (!mem_read || mem_write || mem_addr != ia)) bad_op++;
      end
      if (st) scnt++;
      strobe_s = st;
      if (i_ready && d_ready) coincide++;
      if (i_ready) begin ip--; idrop = 1; end
      if (d_ready) begin dp--; ddrop = 1; end
    end
    left = ip + dp;
    mem_ready = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl[5];
    logic [DW-1:0] exp_i, exp_d;
    int first_s, scyc, own, oth, n, coincide, bad_op, left, cnt;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_wd;
    logic [1:0] s_op;
    logic [15:0] ord;

    // ---------------- reset state
    i_read = 1'b1; i_addr = 28'h123; d_read = 1'b1; d_addr = 28'h456; mem_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_read", mem_read, 1'b0);
    chk("rst_mem_write", mem_write, 1'b0);
    chk("rst_i_ready", i_ready, 1'b0);
    chk("rst_d_ready", d_ready, 1'b0);
    chk("rst_mem_addr", mem_addr, '0);
    chk("rst_mem_wdata", mem_wdata, '0);
    chk("rst_i_rdata", i_rdata, '0);
    chk("rst_d_rdata", d_rdata, '0);
    do_reset();

    // ---------------- single-requester vector table
    tbl[0] = '{1'b1, 1'b0, 28'h0000010, '0, 3, {16{8'hA5}}, {16{8'hA5}}};
    tbl[1] = '{1'b0, 1'b0, 28'h0000020, '0, 1, 128'h1111, 128'h1111};
    tbl[2] = '{1'b1, 1'b1, 28'h0000030, 128'h1234, 2, 128'hDEAD, {16{8'hA5}}};
    tbl[3] = '{1'b0, 1'b0, 28'hFFFFFFF, '0, 5, {DW{1'b1}}, {DW{1'b1}}};
    tbl[4] = '{1'b1, 1'b0, 28'h0000000, '0, 1, '0, '0};
    exp_i = '0; exp_d = '0;
    for (int t = 0; t < 5; t++) begin
      do_txn(tbl[t], first_s, scyc, own, oth, s_addr, s_wd, s_op);
      chk($sformatf("v%0d_first_strobe", t), first_s, 1);
      chk($sformatf("v%0d_strobe_cycles", t), scyc, tbl[t].lat);
      chk($sformatf("v%0d_own_ready", t), own, 1);
      chk($sformatf("v%0d_other_ready", t), oth, 0);
      chk($sformatf("v%0d_addr", t), s_addr, tbl[t].addr);
      chk($sformatf("v%0d_op", t), s_op, tbl[t].wr ? 2'b10 : 2'b01);
      if (tbl[t].wr) chk($sformatf("v%0d_wdata", t), s_wd, tbl[t].wd);
      if (tbl[t].sd) exp_d = tbl[t].exp_rdata;
      else exp_i = tbl[t].exp_rdata;
      chk($sformatf("v%0d_i_rdata", t), i_rdata, exp_i);
      chk($sformatf("v%0d_d_rdata", t), d_rdata, exp_d);
    end

    // ---------------- simultaneous I read / D write after reset
    do_reset();
    contend(1, 1, 28'h0000020, 28'h0000030, 1'b1, 128'h1234, ord, n, coincide, bad_op, left);
    chk("both_count", n, 2);
    chk("both_order", ord[1:0], 2'b10);
    chk("both_ops", bad_op, 0);
    chk("both_coincide", coincide, 0);
    chk("both_done", left, 0);

    // ---------------- continuous contention; D must win first again since I was granted last
    contend(3, 3, 28'h0000100, 28'h0000200, 1'b0, '0, ord, n, coincide, bad_op, left);
    chk("alt_count", n, 6);
    chk("alt_order", ord[5:0], 6'b101010);
    chk("alt_ops", bad_op, 0);
    chk("alt_coincide", coincide, 0);
    chk("alt_done", left, 0);

    // ---------------- reset in the middle of BUSY_I, memory never answers
    do_reset();
    @(negedge clk);
    i_read = 1'b1; i_addr = 28'h0000040;
    @(posedge clk); #1;
    chk("abort_strobe_up", mem_read, 1'b1);
    @(negedge clk);
    @(negedge clk);
    proc_reset = 1'b1; i_read = 1'b0;
    @(posedge clk); #1;
    chk("abort_strobe_low", mem_read, 1'b0);
    chk("abort_addr_clr", mem_addr, '0);
    @(negedge clk);
    proc_reset = 1'b0;
    cnt = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      cnt += int'(i_ready) + int'(mem_read) + int'(mem_write);
    end
    chk("abort_quiet", cnt, 0);
    @(negedge clk);
    d_read = 1'b1; d_addr = 28'h0000050;
    @(posedge clk); #1;
    chk("abort_idle_grant", {mem_read, mem_addr}, {1'b1, 28'h0000050});
    @(negedge clk);
    mem_ready = 1'b1; mem_rdata = 128'h55;
    @(posedge clk); #1;
    chk("abort_after_ready", d_ready, 1'b1);
    @(negedge clk);
    clear_inputs();
    @(negedge clk);

    // ---------------- malformed D request, then abandonment mid-transaction
    d_read = 1'b1; d_write = 1'b1; d_addr = 28'h0000060;
    cnt = 0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      cnt += int'(mem_read) + int'(mem_write);
      @(negedge clk);
    end
    chk("rw_both_no_strobe", cnt, 0);
    d_write = 1'b0;
    @(posedge clk); #1;
    chk("aband_strobe", mem_read, 1'b1);
    @(negedge clk);
    d_read = 1'b0;
    @(posedge clk); #1;
    chk("aband_held", {mem_read, mem_addr}, {1'b1, 28'h0000060});
    @(negedge clk);
    mem_ready = 1'b1; mem_rdata = 128'h77;
    cnt = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      cnt += int'(d_ready);
      @(negedge clk);
      mem_ready = 1'b0;
    end
    chk("aband_ready_once", cnt, 1);
    chk("aband_rdata", d_rdata, 128'h77);
    chk("aband_rdata_i_held", i_rdata, 128'h55 & '0);

    // ---------------- randomized run against a transaction-level model
    do_reset();
    begin
      bit ipend, dpend, idrop, ddrop, dwr, strobe_s, prev_acc, acc, mr, st;
      bit i_lvl, d_lvl, last_side, cur_side, cur_wr, exp_side;
      logic [AW-1:0] ia, da, held_addr;
      logic [DW-1:0] dwd, rdv;
      int lat_cnt, ntx;
      ipend = 0; dpend = 0; idrop = 0; ddrop = 0; dwr = 0; strobe_s = 0; prev_acc = 0;
      last_side = 1'b0; cur_side = 0; cur_wr = 0; lat_cnt = 0; ntx = 0;
      ia = '0; da = '0; dwd = '0; held_addr = '0; rdv = '0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
        @(negedge clk);
        if (idrop) begin
          i_read = 1'b0; ipend = 0; idrop = 0;
        end else if (!ipend && $urandom_range(0, 2) == 0) begin
          ipend = 1; ia = {1'b0, 27'($urandom)}; i_read = 1'b1; i_addr = ia;
        end
        if (ddrop) begin
          d_read = 1'b0; d_write = 1'b0; dpend = 0; ddrop = 0;
        end else if (!dpend && $urandom_range(0, 2) == 0) begin
          dpend = 1; da = {1'b1, 27'($urandom)}; dwr = 1'($urandom);
          dwd = {$urandom, $urandom, $urandom, $urandom};
          d_addr = da; d_wdata = dwd; d_read = !dwr; d_write = dwr;
        end
        if (strobe_s) begin
          mr = (lat_cnt == 0);
          if (!mr) lat_cnt--;
        end else begin
          mr = ($urandom_range(0, 7) == 0);
        end
        rdv = {$urandom, $urandom, $urandom, $urandom};
        mem_ready = mr; mem_rdata = rdv;
        acc = mr && strobe_s;
        i_lvl = i_read; d_lvl = d_read ^ d_write;
        @(posedge clk); #1;
        st = mem_read || mem_write;
        chk("r_strobe_excl", mem_read & mem_write, 1'b0);
        if (acc) begin
          chk("r_strobe_drop", st, 1'b0);
          chk("r_i_ready", i_ready, !cur_side);
          chk("r_d_ready", d_ready, cur_side);
          if (!cur_wr) chk("r_rdata", cur_side ? d_rdata : i_rdata, rdv);
        end else begin
          chk("r_no_ready", {i_ready, d_ready}, 2'b00);
          if (strobe_s) begin
            chk("r_hold", {st, mem_addr}, {1'b1, held_addr});
          end else if (prev_acc) begin
            chk("r_done_gap", st, 1'b0);
          end else if (st) begin
            if (i_lvl && d_lvl) exp_side = !last_side;
            else exp_side = d_lvl;
            chk("r_grant_has_req", i_lvl | d_lvl, 1'b1);
            chk("r_grant_addr", mem_addr, exp_side ? da : ia);
            chk("r_grant_op", {mem_write, mem_read}, (exp_side && dwr) ? 2'b10 : 2'b01);
            if (exp_side && dwr) chk("r_grant_wdata", mem_wdata, dwd);
            last_side = exp_side; cur_side = exp_side; cur_wr = exp_side && dwr;
            held_addr = mem_addr;
            lat_cnt = $urandom_range(0, 3);
            ntx++;
          end else begin
            chk("r_idle_no_grant", i_lvl | d_lvl, 1'b0);
          end
        end
        if (i_ready) idrop = 1;
        if (d_ready) ddrop = 1;
        strobe_s = st;
        prev_acc = acc;
      end
      chk("r_activity", ntx >= 100, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/l2_mem_arbiter.md
L2_MEM_ARBITER -- requirements
Module: l2_mem_arbiter

Interface
REQ-001 Clock and reset SHALL be as follows: one clock `clk`; reset is `proc_reset`, synchronous, active-high.
REQ-002 Parameter SHALL be ADDR_W, default 28: block address width (128-bit line granularity).
REQ-003 Parameter SHALL be DATA_W, default 128: line width.
REQ-004 Port list SHALL be:
- clk  in  1  clock
- proc_reset  in  1  sync active-high reset
- i_read  in  1  I-side L2 miss read request
- i_addr  in  ADDR_W  I-side block address
- i_rdata  out  DATA_W  I-side returned line
- i_ready  out  1  I-side completion pulse
- d_read  in  1  D-side read request
- d_write  in  1  D-side write request
- d_addr  in  ADDR_W  D-side block address
- d_wdata  in  DATA_W  D-side write line
- d_rdata  out  DATA_W  D-side returned line
- d_ready  out  1  D-side completion pulse
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data
- mem_ready  in  1  memory completion, one-cycle

Function
REQ-005 Requester handshake SHALL be level-based: a requester holds its request and its address/data stable until it samples its ready high, then drops the request the next cycle.
REQ-006 D-side with d_read and d_write both high SHALL count as no request.
REQ-007 FSM states SHALL be IDLE, BUSY_I, BUSY_D, DONE. All outputs are registered.
REQ-008 IDLE transitions SHALL be:
- Only I requests: go to BUSY_I.
- Only D requests: go to BUSY_D.
- Neither requests: stay in IDLE.
REQ-009 When both request in IDLE, the grant SHALL go to the requester not recorded in the 1-bit register last_grant (round-robin).
REQ-010 last_grant SHALL update on every grant.
REQ-011 On grant, address, wdata and operation SHALL be latched; memory is driven from the latches only. Requester inputs are ignored until DONE.
REQ-012 Strobe timing SHALL be: a request sampled in IDLE at edge N gives mem_read or mem_write high from cycle N+1.
REQ-013 Strobe, mem_addr and mem_wdata SHALL be held constant while BUSY_x and mem_ready is low.
REQ-014 When mem_ready is sampled high in BUSY_x at edge M:
- Strobes go low in cycle M+1.
- mem_rdata is captured into the granted side's rdata register (reads only; writes leave rdata unchanged).
- The granted side's ready is high for exactly cycle M+1 (state DONE).
REQ-015 DONE SHALL last one cycle, ignore all requests, and go to IDLE. Minimum issue-to-issue spacing is therefore 2 idle cycles after mem_ready.
REQ-016 i_rdata and d_rdata SHALL hold their last value between transactions.
REQ-017 At most one of mem_read or mem_write SHALL be high in any cycle. i_ready and d_ready are never high together.
REQ-018 Requester abandonment: if the granted requester drops its request mid-transaction, the memory transaction SHALL still complete, and the ready pulse is still issued in DONE.
REQ-019 mem_ready seen in IDLE or DONE SHALL be ignored.

Reset
REQ-020 While proc_reset is sampled high, the arbiter SHALL:
- Go to IDLE.
- Set last_grant = I, so D wins the first contention.
- Clear mem_read, mem_write, i_ready, d_ready, mem_addr, mem_wdata, i_rdata and d_rdata to 0.
REQ-021 Reset asserted mid-BUSY SHALL abort: strobes go low the cycle after the reset edge, and no ready pulse is issued.

Structure
REQ-022 A shared package SHALL hold the ADDR_W/DATA_W defaults and the FSM state encoding (2-bit: IDLE=0, BUSY_I=1, BUSY_D=2, DONE=3).
REQ-023 Round-robin pick logic SHALL be one sub-module, rr_pick2: 2 requests plus last_grant in, one-hot grant out, combinational.

Verification
REQ-024 D read at addr 0x0000010 alone, memory ready after 3 cycles with rdata 0xA5..A5:
- Required response: mem_read high for 3 cycles with mem_addr 0x0000010; d_rdata = 0xA5..A5; d_ready one pulse; i_ready stays 0.
REQ-025 I read at 0x0000020 and D write at 0x0000030 (wdata 0x1234) raised in the same cycle after reset:
- Required response: D served first (mem_write, 0x0000030, 0x1234), then I (mem_read, 0x0000020); last_grant ends = I.
REQ-026 Both sides requesting continuously for 6 transactions:
- Required response: grants alternate D, I, D, I, D, I; no ready ever coincides.
REQ-027 proc_reset pulsed during BUSY_I with mem_ready never arriving:
- Required response: mem_read low the next cycle; i_ready never pulses; state IDLE.
REQ-028 d_read and d_write both high for 5 cycles:
- Required response: no memory strobe. Then D drops its request during BUSY_D: transaction completes and d_ready pulses once.
